reg_write_arbiter: RTL and testbench

Shares the single write port of the four-entry, 16-bit general-purpose register file between two writeback requesters: the ALU and the memory/load unit. It sits between the writeback sources and the register file. It drives the register file's `write_enable`, `store_at` and write-data inputs from one registered output stage. It also keeps a per-register pending scoreboard so the issue logic can stall on read-after-write hazards.

---
 rtl/reg_write_arbiter.sv | 119 +++++++++++
 tb/tb_reg_write_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Write-port arbiter for the 4-entry register file: round-robin ALU/MEM grant, registered
// write stage, per-register pending scoreboard and a saturating contention counter.
module reg_write_arbiter #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned STALL_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_req,
  input  logic [1:0]                 alu_dest,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  output logic                       alu_grant,
  input  logic                       mem_req,
  input  logic [1:0]                 mem_dest,
  input  logic [DATA_WIDTH-1:0]      mem_data,
  output logic                       mem_grant,
  input  logic                       reserve_valid,
  input  logic [1:0]                 reserve_dest,
  output logic [3:0]                 busy,
  output logic                       write_enable,
  output logic [1:0]                 store_at,
  output logic [DATA_WIDTH-1:0]      write_data,
  output logic                       write_done,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  typedef enum logic {SrcAlu, SrcMem} src_e;

  localparam logic [STALL_CNT_WIDTH-1:0] StallOne = STALL_CNT_WIDTH'(1);
  localparam logic [STALL_CNT_WIDTH-1:0] StallMax = '1;

  src_e                       last_grant_q, last_grant_d;
  logic                       xfer;
  logic [1:0]                 xfer_dest;
  logic [DATA_WIDTH-1:0]      xfer_data;
  logic                       we_q;
  logic                       done_q;
  logic [1:0]                 store_at_q;
  logic [DATA_WIDTH-1:0]      data_q;
  logic [3:0]                 busy_q, busy_d;
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

  // A tie goes to whichever requester did not win the previous transfer.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (!reset) begin
      if (alu_req && mem_req) begin
        alu_grant = (last_grant_q == SrcMem);
        mem_grant = (last_grant_q == SrcAlu);
      end else begin
        alu_grant = alu_req;
        mem_grant = mem_req;
      end
    end
  end

  always_comb begin
    xfer         = alu_grant | mem_grant;
    xfer_dest    = alu_grant ? alu_dest : mem_dest;
    xfer_data    = alu_grant ? alu_data : mem_data;
    last_grant_d = last_grant_q;
    if (alu_grant) begin
      last_grant_d = SrcAlu;
    end else if (mem_grant) begin
      last_grant_d = SrcMem;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (alu_req && mem_req && (stall_q != StallMax)) begin
      stall_d = stall_q + StallOne;
    end
  end

  // A new reservation outranks the write completing in the same cycle.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (reserve_valid && (reserve_dest == i[1:0])) begin
        busy_d[i] = 1'b1;
      end else if (write_enable && (store_at == i[1:0])) begin
        busy_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= SrcMem;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
      store_at_q   <= 2'b00;
      data_q       <= '0;
      busy_q       <= 4'b0000;
      stall_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= xfer;
      done_q       <= write_enable;
      busy_q       <= busy_d;
      stall_q      <= stall_d;
      if (xfer) begin
        store_at_q <= xfer_dest;
        data_q     <= xfer_data;
      end
    end
  end

  // Masking with reset drops a write captured just before reset rose.
  assign write_enable = we_q & ~reset;
  assign write_done   = done_q;
  assign store_at     = store_at_q;
  assign write_data   = data_q;
  assign busy         = busy_q;
  assign stall_count  = stall_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: scoreboard of expected register-file writes plus a
// cycle-level reference model of grants, scoreboard bits and the stall counter.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_req, mem_req, reserve_valid;
  logic [1:0]  alu_dest, mem_dest, reserve_dest;
  logic [15:0] alu_data, mem_data;

  logic        alu_grant, mem_grant, write_enable, write_done;
  logic [3:0]  busy;
  logic [1:0]  store_at;
  logic [15:0] write_data;
  logic [7:0]  stall_count;

  logic        alu_grant2, mem_grant2, write_enable2, write_done2;
  logic [3:0]  busy2;
  logic [1:0]  store_at2;
  logic [15:0] write_data2;
  logic [1:0]  stall_count2;

  reg_write_arbiter #(.DATA_WIDTH(16), .STALL_CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .alu_req(alu_req), .alu_dest(alu_dest), .alu_data(alu_data), .alu_grant(alu_grant),
    .mem_req(mem_req), .mem_dest(mem_dest), .mem_data(mem_data), .mem_grant(mem_grant),
    .reserve_valid(reserve_valid), .reserve_dest(reserve_dest), .busy(busy),
    .write_enable(write_enable), .store_at(store_at), .write_data(write_data),
    .write_done(write_done), .stall_count(stall_count)
  );

  reg_write_arbiter #(.DATA_WIDTH(16), .STALL_CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset),
    .alu_req(alu_req), .alu_dest(alu_dest), .alu_data(alu_data), .alu_grant(alu_grant2),
    .mem_req(mem_req), .mem_dest(mem_dest), .mem_data(mem_data), .mem_grant(mem_grant2),
    .reserve_valid(reserve_valid), .reserve_dest(reserve_dest), .busy(busy2),
    .write_enable(write_enable2), .store_at(store_at2), .write_data(write_data2),
    .write_done(write_done2), .stall_count(stall_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  d;
    logic [15:0] v;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference state
  bit          m_last_alu;
  bit [3:0]    m_busy;
  int          m_stall, m_stall2;
  bit          pend_v, done_exp;
  bit [1:0]    pend_d;
  bit          g_alu, g_mem;
  logic [15:0] m_regs[4] = '{default: 16'h0};
  logic [15:0] rf[4]     = '{default: 16'h0};

  // Register-file stand-in fed from the DUT's write port
  always @(posedge clk) if (write_enable === 1'b1) rf[store_at] <= write_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every issued write must match the oldest outstanding grant.
  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h@%0d required=none", write_data, store_at);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("store_at", 32'(store_at), 32'(e.d));
        chk("write_data", 32'(write_data), 32'(e.v));
        m_regs[e.d] = e.v;
      end
    end
  end

  // One clock: check grants for the applied inputs, cross the edge, check registered state.
  task automatic cycle();
    bit ga, gm, tie, rst, rv;
    bit [1:0] rd;
    #1;
    ga = 1'b0;
    gm = 1'b0;
    if (!reset) begin
      if (alu_req && mem_req) begin
        if (m_last_alu) gm = 1'b1;
        else ga = 1'b1;
      end else begin
        ga = alu_req;
        gm = mem_req;
      end
    end
    chk("alu_grant", 32'(alu_grant), 32'(ga));
    chk("mem_grant", 32'(mem_grant), 32'(gm));
    if (reset) chk("we_in_reset", 32'(write_enable), 32'(0));
    if (ga) exp_q.push_back('{d: alu_dest, v: alu_data});
    if (gm) exp_q.push_back('{d: mem_dest, v: mem_data});
    g_alu = ga;
    g_mem = gm;
    tie   = alu_req && mem_req && !reset;
    rst   = reset;
    rv    = reserve_valid;
    rd    = reserve_dest;
    @(posedge clk);
    #1;
    if (rst) begin
      m_busy     = 4'b0;
      m_stall    = 0;
      m_stall2   = 0;
      m_last_alu = 1'b0;
      pend_v     = 1'b0;
      done_exp   = 1'b0;
      exp_q.delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (rv && rd == 2'(i)) m_busy[i] = 1'b1;
        else if (pend_v && pend_d == 2'(i)) m_busy[i] = 1'b0;
      end
      done_exp = pend_v;
      pend_v   = ga | gm;
      pend_d   = ga ? alu_dest : mem_dest;
      if (ga) m_last_alu = 1'b1;
      if (gm) m_last_alu = 1'b0;
      if (tie) begin
        m_stall  = (m_stall < 255) ? m_stall + 1 : 255;
        m_stall2 = (m_stall2 < 3) ? m_stall2 + 1 : 3;
      end
    end
    chk("write_enable", 32'(write_enable), 32'(pend_v));
    chk("write_done", 32'(write_done), 32'(done_exp));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("stall_count", 32'(stall_count), 32'(m_stall));
    chk("stall_count_w2", 32'(stall_count2), 32'(m_stall2));
  endtask

  task automatic idle();
    alu_req       = 1'b0;
    mem_req       = 1'b0;
    reserve_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < 4; i++) chk(name, 32'(rf[i]), 32'(m_regs[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_dest = 2'd0; alu_data = 16'h0; mem_dest = 2'd0; mem_data = 16'h0;
    reserve_dest = 2'd0;
    do_reset();
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_stall", 32'(stall_count), 32'(0));
    chk("reset_store_at", 32'(store_at), 32'(0));
    chk("reset_write_data", 32'(write_data), 32'(0));

    // Single ALU write to C
    alu_req = 1'b1; alu_dest = 2'b10; alu_data = 16'h1234;
    cycle();
    alu_req = 1'b0;
    cycle();
    cycle();
    chk("regC", 32'(rf[2]), 32'(16'h1234));
    check_regs("regs_t1");

    // Tie, each requester drops once granted
    do_reset();
    alu_req = 1'b1; alu_dest = 2'd0; alu_data = 16'h0001;
    mem_req = 1'b1; mem_dest = 2'd1; mem_data = 16'h0002;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (g_alu) alu_req = 1'b0;
      if (g_mem) mem_req = 1'b0;
    end
    chk("tie_stall", 32'(stall_count), 32'(1));
    check_regs("regs_t2");

    // Continuous contention for 6 cycles
    do_reset();
    alu_req = 1'b1; mem_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      alu_dest = 2'($urandom_range(3)); alu_data = 16'($urandom);
      mem_dest = 2'($urandom_range(3)); mem_data = 16'($urandom);
      cycle();
    end
    idle();
    chk("alt_stall", 32'(stall_count), 32'(6));
    chk("alt_stall_w2", 32'(stall_count2), 32'(3));
    cycle();
    cycle();

    // Scoreboard: reserve B, write B; then the same with a re-reserve on commit
    for (int rr = 0; rr < 2; rr++) begin
      idle();
      reserve_valid = 1'b1; reserve_dest = 2'b01;
      cycle();
      chk("busy_after_reserve", 32'(busy), 32'(4'b0010));
      reserve_valid = 1'b0;
      cycle();
      alu_req = 1'b1; alu_dest = 2'b01; alu_data = 16'hbeef + 16'(rr);
      cycle();
      alu_req = 1'b0;
      reserve_valid = (rr == 1);
      cycle();
      chk("busy_after_commit", 32'(busy), (rr == 1) ? 32'(4'b0010) : 32'(4'b0000));
      idle();
      cycle();
    end

    // Reset right after a grant drops the write
    do_reset();
    alu_req = 1'b1; alu_dest = 2'b11; alu_data = 16'hdead;
    cycle();
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_we", 32'(write_enable), 32'(0));
    chk("rst_done", 32'(write_done), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_stall", 32'(stall_count), 32'(0));
    chk("rst_no_write", 32'(rf[3]), 32'(m_regs[3]));
    alu_req = 1'b1; mem_req = 1'b1;
    cycle();
    chk("first_tie_alu", 32'(g_alu), 32'(1));
    idle();
    cycle();
    cycle();

    // Randomized traffic with valid/hold, occasional drops, reservations and resets
    for (int n = 0; n < 500; n++) begin
      reset = ($urandom_range(63) == 0);
      if (!(alu_req && !g_alu && $urandom_range(9) != 0)) begin
        alu_req = 1'($urandom_range(1)); alu_dest = 2'($urandom_range(3));
        alu_data = 16'($urandom);
      end
      if (!(mem_req && !g_mem && $urandom_range(9) != 0)) begin
        mem_req = 1'($urandom_range(1)); mem_dest = 2'($urandom_range(3));
        mem_data = 16'($urandom);
      end
      reserve_valid = ($urandom_range(3) == 0);
      reserve_dest  = 2'($urandom_range(3));
      cycle();
    end
    reset = 1'b0;
    idle();
    cycle();
    cycle();
    check_regs("regs_rand");

    // Counter saturation
    do_reset();
    alu_req = 1'b1; mem_req = 1'b1;
    for (int i = 0; i < 300; i++) cycle();
    chk("stall_sat", 32'(stall_count), 32'(255));
    chk("stall_sat_w2", 32'(stall_count2), 32'(3));
    idle();
    cycle();
    cycle();
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    check_regs("regs_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
